// File: rtl/darksimv_mem_responder.sv
// Simulation memory for the darkriscv core: a registered instruction fetch port plus a
// wait-stated data port with byte-lane writes, access-error reporting and access counters.
module darksimv_mem_responder #(
    parameter int MEM_DEPTH = 1024,
    parameter int RD_WAIT   = 1,
    parameter int WR_WAIT   = 1
) (
    input  logic        CLK,
    input  logic        RESN,
    input  logic [31:0] IADDR,
    output logic [31:0] IDATA,
    input  logic [31:0] DADDR,
    input  logic [31:0] DATAO,
    output logic [31:0] DATAI,
    input  logic [2:0]  DLEN,
    input  logic        DRD,
    input  logic        DWR,
    input  logic        DAS,
    output logic        HLT,
    output logic        ERR,
    output logic [15:0] RDCNT,
    output logic [15:0] WRCNT
);
    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] { IDLE, WAIT, DONE } state_t;

    logic [31:0]   mem [MEM_DEPTH];
    state_t        state, state_next;
    logic [3:0]    wait_cnt, wait_cnt_next, wait_load;
    logic          req, enter_done;
    logic          len_ok, misaligned, acc_err;
    logic [3:0]    lane_mask;
    logic [AW-1:0] d_idx, i_idx;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_data;
    logic [3:0]    acc_mask;
    logic          acc_wr, acc_bad;
    logic          unused_addr;

    assign req         = DAS & (DRD | DWR);
    assign d_idx       = DADDR[AW+1:2];
    assign i_idx       = IADDR[AW+1:2];
    assign unused_addr = ^{IADDR[31:AW+2], IADDR[1:0], DADDR[31:AW+2]};
    assign wait_load   = DWR ? 4'(WR_WAIT - 1) : 4'(RD_WAIT - 1);
    assign acc_err     = !len_ok | misaligned | (DRD & DWR);

    always_comb begin
        lane_mask  = 4'b0000;
        misaligned = 1'b0;
        len_ok     = 1'b1;
        case (DLEN)
            3'b001: lane_mask = 4'b0001 << DADDR[1:0];
            3'b010: begin
                lane_mask  = DADDR[1] ? 4'b1100 : 4'b0011;
                misaligned = DADDR[0];
            end
            3'b100: begin
                lane_mask  = 4'b1111;
                misaligned = |DADDR[1:0];
            end
            default: len_ok = 1'b0;
        endcase
    end

    // A wait of one cycle skips WAIT entirely so the request cycle is the only stalled one.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        HLT           = 1'b0;
        enter_done    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    HLT           = 1'b1;
                    wait_cnt_next = wait_load;
                    if (wait_load == 4'd0) begin
                        state_next = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                HLT           = 1'b1;
                wait_cnt_next = wait_cnt - 4'd1;
                if (wait_cnt <= 4'd1) begin
                    state_next = DONE;
                    enter_done = 1'b1;
                end
            end
            DONE: begin
                state_next    = IDLE;
                wait_cnt_next = 4'd0;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // The access is captured on entry to DONE while the core still holds its inputs stable.
    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            acc_idx  <= '0;
            acc_data <= '0;
            acc_mask <= '0;
            acc_wr   <= 1'b0;
            acc_bad  <= 1'b0;
            DATAI    <= '0;
            ERR      <= 1'b0;
        end else begin
            ERR <= enter_done & acc_err;
            if (enter_done) begin
                acc_idx  <= d_idx;
                acc_data <= DATAO;
                acc_mask <= lane_mask;
                acc_wr   <= DWR;
                acc_bad  <= acc_err;
                if (acc_err) begin
                    DATAI <= '0;
                end else if (!DWR) begin
                    DATAI <= mem[d_idx];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            RDCNT <= '0;
            WRCNT <= '0;
        end else if (state == DONE && !acc_bad) begin
            if (acc_wr) begin
                WRCNT <= WRCNT + 16'd1;
            end else begin
                RDCNT <= RDCNT + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            IDATA <= '0;
        end else begin
            IDATA <= mem[i_idx];
        end
    end

    // Memory is never reset; the write lands on the edge that ends DONE.
    always_ff @(posedge CLK) begin
        if (state == DONE && acc_wr && !acc_bad) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_mask[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_darksimv_mem_responder.sv
// Randomized bench for darksimv_mem_responder: two instances with different wait settings,
// each checked every cycle against a word-array model of the memory and the access rules.
module tb_darksimv_mem_responder;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resn  [2];
    logic [31:0] iaddr [2];
    logic [31:0] daddr [2];
    logic [31:0] datao [2];
    logic [2:0]  dlen  [2];
    logic        drd   [2];
    logic        dwr   [2];
    logic        das   [2];

    wire [31:0] idata0, idata1, datai0, datai1;
    wire        hlt0, hlt1, err0, err1;
    wire [15:0] rdcnt0, rdcnt1, wrcnt0, wrcnt1;

    darksimv_mem_responder #(.MEM_DEPTH(DEPTH), .RD_WAIT(1), .WR_WAIT(1)) dut0 (
        .CLK(clk), .RESN(resn[0]), .IADDR(iaddr[0]), .IDATA(idata0),
        .DADDR(daddr[0]), .DATAO(datao[0]), .DATAI(datai0), .DLEN(dlen[0]),
        .DRD(drd[0]), .DWR(dwr[0]), .DAS(das[0]), .HLT(hlt0), .ERR(err0),
        .RDCNT(rdcnt0), .WRCNT(wrcnt0)
    );

    darksimv_mem_responder #(.MEM_DEPTH(DEPTH), .RD_WAIT(3), .WR_WAIT(2)) dut1 (
        .CLK(clk), .RESN(resn[1]), .IADDR(iaddr[1]), .IDATA(idata1),
        .DADDR(daddr[1]), .DATAO(datao[1]), .DATAI(datai1), .DLEN(dlen[1]),
        .DRD(drd[1]), .DWR(dwr[1]), .DAS(das[1]), .HLT(hlt1), .ERR(err1),
        .RDCNT(rdcnt1), .WRCNT(wrcnt1)
    );

    logic [31:0] model_mem [2][DEPTH];
    bit          known [2][DEPTH];
    logic [31:0] model_datai [2];
    logic [15:0] model_rd [2];
    logic [15:0] model_wr [2];
    bit          pend_wr [2];
    int          pend_idx [2];
    logic [31:0] pend_data [2];
    logic [3:0]  pend_en [2];
    logic [31:0] exp_idata [2];
    bit          idata_known [2];
    bit          use_fix [2];
    logic [31:0] fix_iaddr [2];

    logic [31:0] last_idata, last_datai;
    logic [15:0] last_rdcnt, last_wrcnt;
    logic        last_hlt, last_err;

    int tests = 0;
    int fails = 0;

    function automatic int rd_wait(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int wr_wait(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic checkCycle(input int d, input string tag, input bit hlt_exp, input bit err_exp);
        string t;
        t = $sformatf("d%0d_%s", d, tag);
        @(negedge clk);
        last_hlt   = (d == 0) ? hlt0   : hlt1;
        last_err   = (d == 0) ? err0   : err1;
        last_datai = (d == 0) ? datai0 : datai1;
        last_idata = (d == 0) ? idata0 : idata1;
        last_rdcnt = (d == 0) ? rdcnt0 : rdcnt1;
        last_wrcnt = (d == 0) ? wrcnt0 : wrcnt1;
        checkOutput({t, "_hlt"},   32'(last_hlt),   32'(hlt_exp));
        checkOutput({t, "_err"},   32'(last_err),   32'(err_exp));
        checkOutput({t, "_datai"}, last_datai,      model_datai[d]);
        checkOutput({t, "_rdcnt"}, 32'(last_rdcnt), 32'(model_rd[d]));
        checkOutput({t, "_wrcnt"}, 32'(last_wrcnt), 32'(model_wr[d]));
        if (idata_known[d]) checkOutput({t, "_idata"}, last_idata, exp_idata[d]);
    endtask

    // Fetch expectation is taken before the edge so a same-edge write yields the old word.
    task automatic nextCycle(input int d);
        int ii;
        ii = int'(iaddr[d][5:2]);
        exp_idata[d]   = model_mem[d][ii];
        idata_known[d] = known[d][ii];
        @(posedge clk);
        if (pend_wr[d]) begin
            for (int b = 0; b < 4; b++)
                if (pend_en[d][b]) model_mem[d][pend_idx[d]][8*b +: 8] = pend_data[d][8*b +: 8];
            known[d][pend_idx[d]] = 1'b1;
            pend_wr[d] = 1'b0;
        end
        #1;
        iaddr[d] = use_fix[d] ? fix_iaddr[d] : $urandom;
    endtask

    task automatic applyStimulus(input int d, input bit rd, input bit wr,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [2:0] len);
        bit         bad;
        int         w, idx;
        logic [3:0] en;
        bad = (rd && wr) || !(len == 3'b001 || len == 3'b010 || len == 3'b100) ||
              (len == 3'b010 && addr[0]) || (len == 3'b100 && addr[1:0] != 2'b00);
        w   = wr ? wr_wait(d) : rd_wait(d);
        idx = int'(addr[5:2]);
        for (int b = 0; b < 4; b++)
            en[b] = (len == 3'b100) || (len == 3'b010 && (b / 2) == int'(addr[1])) ||
                    (len == 3'b001 && b == int'(addr[1:0]));
        das[d] = 1'b1; drd[d] = rd; dwr[d] = wr;
        daddr[d] = addr; datao[d] = data; dlen[d] = len;
        for (int c = 0; c < w; c++) begin
            checkCycle(d, "busy", 1'b1, 1'b0);
            nextCycle(d);
        end
        if (bad) model_datai[d] = '0;
        else if (!wr) model_datai[d] = model_mem[d][idx];
        checkCycle(d, "done", 1'b0, bad);
        if (!bad && wr) begin
            pend_wr[d]   = 1'b1;
            pend_idx[d]  = idx;
            pend_data[d] = data;
            pend_en[d]   = en;
            model_wr[d]  = model_wr[d] + 16'd1;
        end else if (!bad) begin
            model_rd[d] = model_rd[d] + 16'd1;
        end
        nextCycle(d);
    endtask

    task automatic idleCycle(input int d);
        das[d]   = 1'($urandom_range(0, 1));
        drd[d]   = das[d] ? 1'b0 : 1'($urandom_range(0, 1));
        dwr[d]   = das[d] ? 1'b0 : 1'($urandom_range(0, 1));
        daddr[d] = $urandom;
        checkCycle(d, "idle", 1'b0, 1'b0);
        nextCycle(d);
    endtask

    task automatic prefill(input int d);
        logic [31:0] r;
        for (int i = 0; i < DEPTH; i++) begin
            r = $urandom;
            applyStimulus(d, 1'b0, 1'b1, {r[31:6], 4'(i), 2'b00}, $urandom, 3'b100);
        end
    endtask

    task automatic randomPhase(input int d);
        logic [31:0] a;
        logic [2:0]  l;
        bit          r, w;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                r = 1'b1; w = 1'b1;
            end else begin
                w = 1'($urandom_range(0, 1)); r = !w;
            end
            case ($urandom_range(0, 3))
                0: l = 3'b001;
                1: l = 3'b010;
                2: l = 3'b100;
                default: l = 3'($urandom);
            endcase
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (l == 3'b010) a[0] = 1'b0;
                else if (l == 3'b100) a[1:0] = 2'b00;
            end
            applyStimulus(d, r, w, a, $urandom, l);
            repeat ($urandom_range(0, 2)) idleCycle(d);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            resn[d] = 1'b0; iaddr[d] = '0; daddr[d] = '0; datao[d] = '0;
            dlen[d] = '0; drd[d] = 1'b0; dwr[d] = 1'b0; das[d] = 1'b0;
            model_datai[d] = '0; model_rd[d] = '0; model_wr[d] = '0;
            pend_wr[d] = 1'b0; idata_known[d] = 1'b0; use_fix[d] = 1'b0; fix_iaddr[d] = '0;
            for (int i = 0; i < DEPTH; i++) known[d][i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            checkCycle(d, "reset", 1'b0, 1'b0);
            checkOutput($sformatf("d%0d_reset_idata", d), last_idata, 32'h0);
        end
        @(posedge clk);
        #1;
        resn[0] = 1'b1;
        resn[1] = 1'b1;

        // Single-wait instance: word write then read, one stalled cycle each
        applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b100);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b100);
        checkOutput("d0_rw_datai", last_datai, 32'hDEADBEEF);
        idleCycle(0);
        checkOutput("d0_rw_wrcnt", 32'(last_wrcnt), 32'd1);
        checkOutput("d0_rw_rdcnt", 32'(last_rdcnt), 32'd1);

        prefill(0);
        // The core replicates a byte store across all DATAO lanes
        applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'h11223344, 3'b100);
        applyStimulus(0, 1'b0, 1'b1, 32'h13, 32'hAAAAAAAA, 3'b001);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b100);
        checkOutput("d0_byte_merge", last_datai, 32'hAA223344);

        use_fix[0] = 1'b1; fix_iaddr[0] = 32'h10; iaddr[0] = 32'h10;
        applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'h5555AAAA, 3'b100);
        idleCycle(0);
        checkOutput("d0_fetch_old", last_idata, 32'hAA223344);
        idleCycle(0);
        checkOutput("d0_fetch_new", last_idata, 32'h5555AAAA);
        use_fix[0] = 1'b0;
        randomPhase(0);

        // Multi-wait instance
        prefill(1);
        applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h0, 3'b100);
        applyStimulus(1, 1'b1, 1'b0, 32'h24, 32'h0, 3'b100);
        idleCycle(1);
        applyStimulus(1, 1'b0, 1'b1, 32'h21, 32'hFFFFFFFF, 3'b010);
        checkOutput("d1_mis_err", 32'(last_err), 32'h1);
        checkOutput("d1_mis_datai", last_datai, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h0, 3'b100);
        applyStimulus(1, 1'b1, 1'b0, 32'h22, 32'h0, 3'b100);
        applyStimulus(1, 1'b1, 1'b0, 32'h28, 32'h0, 3'b000);
        applyStimulus(1, 1'b0, 1'b1, 32'h28, 32'h12345678, 3'b110);
        applyStimulus(1, 1'b1, 1'b1, 32'h2C, 32'h87654321, 3'b100);
        applyStimulus(1, 1'b1, 1'b0, 32'h2C, 32'h0, 3'b100);

        // Reset while a write sits in its wait cycle
        das[1] = 1'b1; drd[1] = 1'b0; dwr[1] = 1'b1;
        daddr[1] = 32'h30; datao[1] = 32'h0BADF00D; dlen[1] = 3'b100;
        checkCycle(1, "rstw_c0", 1'b1, 1'b0);
        nextCycle(1);
        checkCycle(1, "rstw_wait", 1'b1, 1'b0);
        #2;
        resn[1] = 1'b0; das[1] = 1'b0; dwr[1] = 1'b0;
        #1;
        checkOutput("d1_rstw_hlt",   32'(hlt1),   32'h0);
        checkOutput("d1_rstw_err",   32'(err1),   32'h0);
        checkOutput("d1_rstw_datai", datai1,      32'h0);
        checkOutput("d1_rstw_idata", idata1,      32'h0);
        checkOutput("d1_rstw_rdcnt", 32'(rdcnt1), 32'h0);
        checkOutput("d1_rstw_wrcnt", 32'(wrcnt1), 32'h0);
        model_rd[1] = '0; model_wr[1] = '0; model_datai[1] = '0;
        @(posedge clk);
        #1;
        resn[1] = 1'b1;
        exp_idata[1] = 32'h0; idata_known[1] = 1'b1;
        applyStimulus(1, 1'b1, 1'b0, 32'h30, 32'h0, 3'b100);
        randomPhase(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
